// File: rtl/bolme_denetleyici_if.sv
// bolme_denetleyici_if: request/result and divider-side signals of the
// BOL sequencer.
//   slave  : the sequencer itself.
//   master : execute stage plus the shared divider, seen from outside.
`timescale 1ns/1ps
interface bolme_denetleyici_if;
  // execute stage -> sequencer
  logic        istek_i;
  logic [1:0]  islem_i;
  logic [31:0] bolunen_i;
  logic [31:0] bolen_i;
  logic        temizle_i;
  // sequencer -> execute stage
  logic        durdur_o;
  logic        sonuc_gecerli_o;
  logic [31:0] sonuc_o;
  logic        hata_o;
  // sequencer <-> shared divider
  logic        bol_basla_o;
  logic        bol_isaretli_o;
  logic [31:0] bol_bolunen_o;
  logic [31:0] bol_bolen_o;
  logic        bol_bitti_i;
  logic [31:0] bol_bolum_i;
  logic [31:0] bol_kalan_i;

  modport slave (
    input  istek_i, islem_i, bolunen_i, bolen_i, temizle_i,
           bol_bitti_i, bol_bolum_i, bol_kalan_i,
    output durdur_o, sonuc_gecerli_o, sonuc_o, hata_o,
           bol_basla_o, bol_isaretli_o, bol_bolunen_o, bol_bolen_o
  );

  modport master (
    output istek_i, islem_i, bolunen_i, bolen_i, temizle_i,
           bol_bitti_i, bol_bolum_i, bol_kalan_i,
    input  durdur_o, sonuc_gecerli_o, sonuc_o, hata_o,
           bol_basla_o, bol_isaretli_o, bol_bolunen_o, bol_bolen_o
  );
endinterface

// File: rtl/bolme_denetleyici.sv
// bolme_denetleyici: sequencer for the shared iterative divider (DIV/DIVU/
// REM/REMU). Resolves divide-by-zero and signed overflow locally, otherwise
// launches the divider and stalls execute until it completes. Handles
// flushes, a completion timeout (sticky hata_o) and, when the macro
// BOLME_ONBELLEK_EN is defined, a one-entry last-result cache.
`timescale 1ns/1ps
module bolme_denetleyici #(
  parameter int ZAMAN_ASIMI = 64  // cycles without bol_bitti_i before timeout, >= 2
) (
  input logic               clk_i,
  input logic               rst_i,
  bolme_denetleyici_if.slave bus
);

  typedef enum logic [1:0] {BOSTA, BEKLE, IPTAL, SONUC} durum_t;

  localparam int                  SAYAC_W   = $clog2(ZAMAN_ASIMI) + 1;
  localparam logic [SAYAC_W-1:0]  SAYAC_SON = SAYAC_W'(ZAMAN_ASIMI - 1);

  durum_t              r_durum, w_sonraki;
  logic [SAYAC_W-1:0]  r_sayac;
  logic [31:0]         r_bolunen, r_bolen, r_sonuc;
  logic                r_isaretli, r_kalan_sec, r_basla, r_hata;

  logic                w_durdur, w_gecerli, w_yakala, w_sonuc_yukle;
  logic                w_hata_set, w_sayac_say;
  logic [31:0]         w_sonuc_deger;
  logic                w_bolen_sifir, w_tasma, w_zaman_doldu;
  logic                w_onb_isabet;
  logic [31:0]         w_onb_deger;

  assign w_bolen_sifir = (bus.bolen_i == 32'h0);
  assign w_tasma       = ~bus.islem_i[0] && (bus.bolunen_i == 32'h8000_0000) &&
                         (bus.bolen_i == 32'hFFFF_FFFF);
  assign w_zaman_doldu = (r_sayac == SAYAC_SON);

`ifdef BOLME_ONBELLEK_EN
  logic        r_onb_gecerli, r_onb_isaretli;
  logic [31:0] r_onb_bolunen, r_onb_bolen, r_onb_bolum, r_onb_kalan;
  logic        w_onb_yaz;

  // Every divider completion, even for a flushed instruction, refreshes the entry.
  assign w_onb_yaz    = ((r_durum == BEKLE) || (r_durum == IPTAL)) && bus.bol_bitti_i;
  assign w_onb_isabet = r_onb_gecerli && (r_onb_bolunen == bus.bolunen_i) &&
                        (r_onb_bolen == bus.bolen_i) && (r_onb_isaretli == ~bus.islem_i[0]);
  assign w_onb_deger  = bus.islem_i[1] ? r_onb_kalan : r_onb_bolum;

  // Cache valid bit: cleared by reset and by a timeout, set on fill.
  always_ff @(posedge clk_i) begin
    if (rst_i)           r_onb_gecerli <= 1'b0;
    else if (w_hata_set) r_onb_gecerli <= 1'b0;
    else if (w_onb_yaz)  r_onb_gecerli <= 1'b1;
  end

  // Cache payload: operands come from the latched divider request.
  // NOTE: payload needs no reset; the valid bit alone guards it.
  always_ff @(posedge clk_i) begin
    if (w_onb_yaz) begin
      r_onb_bolunen  <= r_bolunen;
      r_onb_bolen    <= r_bolen;
      r_onb_isaretli <= r_isaretli;
      r_onb_bolum    <= bus.bol_bolum_i;
      r_onb_kalan    <= bus.bol_kalan_i;
    end
  end
`else
  assign w_onb_isabet = 1'b0;
  assign w_onb_deger  = 32'h0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so all flops update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_durum <= BOSTA;
    else       r_durum <= w_sonraki;
  end

  // Next state, handshake outputs and datapath strobes.
  always_comb begin
    // NOTE: every output gets a default first, so no path infers a latch.
    w_sonraki     = r_durum;
    w_durdur      = 1'b0;
    w_gecerli     = 1'b0;
    w_yakala      = 1'b0;
    w_sonuc_yukle = 1'b0;
    w_sonuc_deger = 32'h0;
    w_hata_set    = 1'b0;
    w_sayac_say   = 1'b0;
    unique case (r_durum)
      BOSTA: begin
        w_durdur = bus.istek_i & ~bus.temizle_i;
        if (bus.istek_i && !bus.temizle_i) begin
          if (w_bolen_sifir) begin
            w_sonuc_yukle = 1'b1;
            w_sonuc_deger = bus.islem_i[1] ? bus.bolunen_i : 32'hFFFF_FFFF;
            w_sonraki     = SONUC;
          end else if (w_tasma) begin
            w_sonuc_yukle = 1'b1;
            w_sonuc_deger = bus.islem_i[1] ? 32'h0 : 32'h8000_0000;
            w_sonraki     = SONUC;
          end else if (w_onb_isabet) begin
            w_sonuc_yukle = 1'b1;
            w_sonuc_deger = w_onb_deger;
            w_sonraki     = SONUC;
          end else begin
            w_yakala  = 1'b1;
            w_sonraki = BEKLE;
          end
        end
      end
      BEKLE: begin
        w_durdur    = 1'b1;
        w_sayac_say = 1'b1;
        if (bus.bol_bitti_i) begin
          // A flush in the completion cycle simply drops the result.
          w_sonuc_yukle = ~bus.temizle_i;
          w_sonuc_deger = r_kalan_sec ? bus.bol_kalan_i : bus.bol_bolum_i;
          w_sonraki     = bus.temizle_i ? BOSTA : SONUC;
        end else if (w_zaman_doldu) begin
          w_hata_set    = 1'b1;
          w_sonuc_yukle = 1'b1;
          w_sonraki     = bus.temizle_i ? BOSTA : SONUC;
        end else if (bus.temizle_i) begin
          w_sonraki = IPTAL;
        end
      end
      IPTAL: begin
        // Divider cannot be aborted: release the pipeline but hold off new requests.
        w_durdur    = bus.istek_i;
        w_sayac_say = 1'b1;
        if (bus.bol_bitti_i) begin
          w_sonraki = BOSTA;
        end else if (w_zaman_doldu) begin
          w_hata_set = 1'b1;
          w_sonraki  = BOSTA;
        end
      end
      SONUC: begin
        w_gecerli = ~bus.temizle_i;
        w_sonraki = BOSTA;
      end
      default: w_sonraki = BOSTA;
    endcase
  end

  // Divider request latches, registered start pulse, result and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bolunen   <= 32'h0;
      r_bolen     <= 32'h0;
      r_isaretli  <= 1'b0;
      r_kalan_sec <= 1'b0;
      r_basla     <= 1'b0;
      r_sonuc     <= 32'h0;
      r_hata      <= 1'b0;
    end else begin
      r_basla <= w_yakala;
      if (w_yakala) begin
        r_bolunen   <= bus.bolunen_i;
        r_bolen     <= bus.bolen_i;
        r_isaretli  <= ~bus.islem_i[0];
        r_kalan_sec <= bus.islem_i[1];
      end
      if (w_sonuc_yukle) r_sonuc <= w_sonuc_deger;
      if (w_hata_set)    r_hata  <= 1'b1;
    end
  end

  // Timeout counter: restarts with each divider launch, saturates instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i)                               r_sayac <= '0;
    else if (w_yakala)                       r_sayac <= '0;
    else if (w_sayac_say && r_sayac != '1)   r_sayac <= r_sayac + 1'b1;
  end

  assign bus.durdur_o        = w_durdur;
  assign bus.sonuc_gecerli_o = w_gecerli;
  assign bus.sonuc_o         = r_sonuc;
  assign bus.hata_o          = r_hata;
  assign bus.bol_basla_o     = r_basla;
  assign bus.bol_isaretli_o  = r_isaretli;
  assign bus.bol_bolunen_o   = r_bolunen;
  assign bus.bol_bolen_o     = r_bolen;

endmodule

// File: tb/tb_bolme_denetleyici.sv
// tb_bolme_denetleyici: directed bench for bolme_denetleyici. Expected
// results come from a RISC-V division model and are queued when a request
// is issued; a monitor pops and compares them on every sonuc_gecerli_o.
// A second instance with ZAMAN_ASIMI=8 exercises the timeout.
`timescale 1ns/1ps
module tb_bolme_denetleyici;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bolme_denetleyici_if bi ();
  bolme_denetleyici_if ti ();

  bolme_denetleyici u_dut (.clk_i(clk), .rst_i(rst), .bus(bi));
  bolme_denetleyici #(.ZAMAN_ASIMI(8)) u_dut_t (.clk_i(clk), .rst_i(rst), .bus(ti));

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference RISC-V M-extension division semantics.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    if (!op[0]) return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return op[1] ? a % b : a / b;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, hold it while stalled, answer as the divider
  // 'gecikme' cycles after bol_basla_o. Cycle numbers are relative to the request.
  task automatic islem_yap(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int gecikme, output int n_durdur, output int n_basla,
                           output int n_gecerli, output int t_gecerli);
    int t_basla;
    t_basla = -1; n_durdur = 0; n_basla = 0; n_gecerli = 0; t_gecerli = -1;
    sb.push_back(model(op, a, b));
    cyc();
    bi.istek_i = 1'b1; bi.islem_i = op; bi.bolunen_i = a; bi.bolen_i = b;
    for (int t = 0; t < 200; t++) begin
      if (t > 0) cyc();
      bi.bol_bitti_i = (t_basla >= 0) && (t == t_basla + gecikme);
      bi.bol_bolum_i = bi.bol_bitti_i ? model({1'b0, op[0]}, a, b) : 32'h0;
      bi.bol_kalan_i = bi.bol_bitti_i ? model({1'b1, op[0]}, a, b) : 32'h0;
      #3;
      if (bi.durdur_o) n_durdur++;
      if (bi.bol_basla_o) begin
        n_basla++;
        t_basla = t;
        check("basla_bolunen", bi.bol_bolunen_o, a);
        check("basla_bolen", bi.bol_bolen_o, b);
        check("basla_isaretli", {31'h0, bi.bol_isaretli_o}, {31'h0, ~op[0]});
      end
      if (bi.sonuc_gecerli_o) begin
        n_gecerli++;
        t_gecerli = t;
      end
      if (!bi.durdur_o) break;
    end
    cyc();
    bi.istek_i = 1'b0; bi.bol_bitti_i = 1'b0;
  endtask

  // Scoreboard monitor: every result pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bi.sonuc_gecerli_o === 1'b1) begin
      if (sb.size() == 0) check("beklenmeyen_sonuc", {31'h0, bi.sonuc_gecerli_o}, 32'h0);
      else                check("sonuc", bi.sonuc_o, sb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, nb, ng, tg;
    bi.istek_i = 0; bi.islem_i = 0; bi.bolunen_i = 0; bi.bolen_i = 0; bi.temizle_i = 0;
    bi.bol_bitti_i = 0; bi.bol_bolum_i = 0; bi.bol_kalan_i = 0;
    ti.istek_i = 0; ti.islem_i = 0; ti.bolunen_i = 0; ti.bolen_i = 0; ti.temizle_i = 0;
    ti.bol_bitti_i = 0; ti.bol_bolum_i = 0; ti.bol_kalan_i = 0;

    // Reset state
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    #3;
    check("rst_durdur", {31'h0, bi.durdur_o}, 32'h0);
    check("rst_gecerli", {31'h0, bi.sonuc_gecerli_o}, 32'h0);
    check("rst_sonuc", bi.sonuc_o, 32'h0);
    check("rst_hata", {31'h0, bi.hata_o}, 32'h0);
    check("rst_basla", {31'h0, bi.bol_basla_o}, 32'h0);
    check("rst_bolunen", bi.bol_bolunen_o, 32'h0);

    // DIVU 100 / 7, divider answers 10 cycles after start
    islem_yap(2'b01, 32'd100, 32'd7, 10, nd, nb, ng, tg);
    check("divu_durdur_say", nd, 12);
    check("divu_basla_say", nb, 1);
    check("divu_gecerli_say", ng, 1);
    check("divu_gecerli_zaman", tg, 12);

    // Signed overflow special case
    islem_yap(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 3, nd, nb, ng, tg);
    check("tasma_basla_say", nb, 0);
    check("tasma_gecerli_zaman", tg, 1);

    // REM by zero returns the dividend
    islem_yap(2'b10, 32'd25, 32'd0, 3, nd, nb, ng, tg);
    check("sifir_basla_say", nb, 0);
    check("sifir_gecerli_zaman", tg, 1);

    // DIV -17 / 5 through the divider, then REM with the same operands
    islem_yap(2'b00, 32'hFFFF_FFEF, 32'd5, 3, nd, nb, ng, tg);
    check("div_neg_basla_say", nb, 1);
    check("div_neg_gecerli_zaman", tg, 5);
    islem_yap(2'b10, 32'hFFFF_FFEF, 32'd5, 3, nd, nb, ng, tg);
`ifdef BOLME_ONBELLEK_EN
    check("onb_basla_say", nb, 0);
    check("onb_gecerli_zaman", tg, 1);
`else
    check("rem_neg_basla_say", nb, 1);
    check("rem_neg_gecerli_zaman", tg, 5);
`endif

    // Flush during BEKLE: no result for the killed instruction
    cyc(); bi.istek_i = 1; bi.islem_i = 2'b01; bi.bolunen_i = 32'd1000; bi.bolen_i = 32'd10;
    #3; check("iptal_t0_durdur", {31'h0, bi.durdur_o}, 32'h1);
    cyc(); #3; check("iptal_basla", {31'h0, bi.bol_basla_o}, 32'h1);
    cyc();
    cyc(); bi.temizle_i = 1; #3; check("iptal_t3_durdur", {31'h0, bi.durdur_o}, 32'h1);
    cyc(); bi.temizle_i = 0; bi.istek_i = 0; #3;
    check("iptal_durdur_duser", {31'h0, bi.durdur_o}, 32'h0);
    cyc(); bi.istek_i = 1; #3; check("iptal_istek_tut", {31'h0, bi.durdur_o}, 32'h1);
    cyc(); bi.istek_i = 0; bi.bol_bitti_i = 1; bi.bol_bolum_i = 32'd100; bi.bol_kalan_i = 32'd0;
    #3; check("iptal_bitti_gecerli", {31'h0, bi.sonuc_gecerli_o}, 32'h0);
    cyc(); bi.bol_bitti_i = 0; #3;
    check("iptal_sonra_gecerli", {31'h0, bi.sonuc_gecerli_o}, 32'h0);
    islem_yap(2'b01, 32'd81, 32'd9, 4, nd, nb, ng, tg);
    check("iptal_sonra_basla_say", nb, 1);
    check("iptal_sonra_gecerli_zaman", tg, 6);

    // Reset while in BEKLE, then a late bol_bitti_i
    cyc(); bi.istek_i = 1; bi.islem_i = 2'b01; bi.bolunen_i = 32'd50; bi.bolen_i = 32'd5;
    cyc(); #3; check("rst_bekle_basla", {31'h0, bi.bol_basla_o}, 32'h1);
    cyc(); rst = 1; bi.istek_i = 0;
    cyc(); rst = 0; #3;
    check("rst_orta_durdur", {31'h0, bi.durdur_o}, 32'h0);
    check("rst_orta_basla", {31'h0, bi.bol_basla_o}, 32'h0);
    check("rst_orta_sonuc", bi.sonuc_o, 32'h0);
    check("rst_orta_bolunen", bi.bol_bolunen_o, 32'h0);
    check("rst_orta_isaretli", {31'h0, bi.bol_isaretli_o}, 32'h0);
    cyc(); bi.bol_bitti_i = 1; bi.bol_bolum_i = 32'd10; #3;
    check("gec_bitti_gecerli", {31'h0, bi.sonuc_gecerli_o}, 32'h0);
    cyc(); bi.bol_bitti_i = 0; #3;
    check("gec_bitti_sonra_gecerli", {31'h0, bi.sonuc_gecerli_o}, 32'h0);

    // Timeout on the ZAMAN_ASIMI=8 instance
    cyc(); ti.istek_i = 1; ti.islem_i = 2'b01; ti.bolunen_i = 32'd9; ti.bolen_i = 32'd3;
    for (int t = 1; t <= 8; t++) cyc();
    #3;
    check("zaman_t8_hata", {31'h0, ti.hata_o}, 32'h0);
    check("zaman_t8_durdur", {31'h0, ti.durdur_o}, 32'h1);
    cyc(); #3;
    check("zaman_gecerli", {31'h0, ti.sonuc_gecerli_o}, 32'h1);
    check("zaman_sonuc", ti.sonuc_o, 32'h0);
    check("zaman_hata", {31'h0, ti.hata_o}, 32'h1);
    cyc(); ti.istek_i = 0;
    cyc(); cyc(); cyc(); #3;
    check("zaman_hata_kalici", {31'h0, ti.hata_o}, 32'h1);
    cyc(); rst = 1;
    cyc(); rst = 0; #3;
    check("zaman_rst_hata", {31'h0, ti.hata_o}, 32'h0);

    cyc(); cyc();
    check("kuyruk_bos", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
